// File: rtl/decode_stage_pkg.sv
// Shared decode-stage constants: opcode encodings and default field widths.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package decode_stage_pkg;

   // Default instruction geometry: [op:2][rd:2][rs:2][..] with imm in the low bits.
   localparam int DEF_INST_W = 8;
   localparam int DEF_OP_W   = 2;
   localparam int DEF_REG_W  = 2;

   // Opcode encodings for the default 2-bit opcode field.
   localparam logic [DEF_OP_W-1:0] OP_ADD   = 2'd0;
   localparam logic [DEF_OP_W-1:0] OP_EMPTY = 2'd1;
   localparam logic [DEF_OP_W-1:0] OP_LI    = 2'd2;
   localparam logic [DEF_OP_W-1:0] OP_BNE   = 2'd3;

endpackage

// File: rtl/decode_stage_op_decode.sv
// Opcode to one-hot class decode, with a mask of which opcodes are legal.
// Latency: purely combinational.
// Backpressure: none, no state.
module op_decode #(
   parameter int                  OP_W  = 2,
   parameter logic [2**OP_W-1:0]  OP_EN = '1
) (
   input  logic [OP_W-1:0]        op,
   output logic [2**OP_W-1:0]     op_type,
   output logic                   illegal
);

   // Masked-off opcodes decode to no class and raise illegal instead.
   always_comb begin
      op_type = '0;
      illegal = 1'b0;
      if (OP_EN[op]) begin
         op_type[op] = 1'b1;
      end else begin
         illegal = 1'b1;
      end
   end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: one-entry pipeline register of decoded fields plus per-opcode retire counters.
// Latency: 1 cycle from capture to out_valid; counters update the cycle after the handshake.
// Backpressure: in_ready = !out_valid || out_ready, so the register refills in the cycle it drains.
module decode_stage
   import decode_stage_pkg::*;
#(
   parameter int                 INST_W = DEF_INST_W,
   parameter int                 OP_W   = DEF_OP_W,
   parameter int                 REG_W  = DEF_REG_W,
   parameter int                 IMM_W  = INST_W - OP_W - REG_W,
   parameter logic [2**OP_W-1:0] OP_EN  = '1,
   parameter int                 CNT_W  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [INST_W-1:0]     in_inst,
   input  logic                  flush,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [2**OP_W-1:0]    out_type,
   output logic [REG_W-1:0]      out_rd,
   output logic [REG_W-1:0]      out_rs,
   output logic [IMM_W-1:0]      out_imm,
   output logic                  out_illegal,
   input  logic [OP_W-1:0]       cnt_sel,
   output logic [CNT_W-1:0]      cnt_val
);

   localparam int NUM_OP = 2**OP_W;

   // Raw fields of the incoming instruction; imm deliberately overlaps rs.
   logic [OP_W-1:0]   in_op;
   logic [REG_W-1:0]  in_rd;
   logic [REG_W-1:0]  in_rs;
   logic [IMM_W-1:0]  in_imm;

   assign in_op  = in_inst[INST_W-1 -: OP_W];
   assign in_rd  = in_inst[INST_W-OP_W-1 -: REG_W];
   assign in_rs  = in_inst[INST_W-OP_W-REG_W-1 -: REG_W];
   assign in_imm = in_inst[IMM_W-1:0];

   logic [NUM_OP-1:0] dec_type;
   logic              dec_illegal;

   op_decode #(
      .OP_W  (OP_W),
      .OP_EN (OP_EN)
   ) u_op_decode (
      .op      (in_op),
      .op_type (dec_type),
      .illegal (dec_illegal)
   );

   // Held opcode is kept separately because out_type is zero for illegal entries.
   logic [OP_W-1:0]   op_q;
   logic [CNT_W-1:0]  cnt_q [NUM_OP];

   logic capture;
   logic retire;

   // Ready depends only on registered state and out_ready, never on in_valid.
   assign in_ready = !out_valid || out_ready;
   assign capture  = in_valid && in_ready && !flush;
   // A flushed entry leaves without being retired, even if downstream was ready.
   assign retire   = out_valid && out_ready && !flush;

   assign cnt_val  = cnt_q[cnt_sel];

   // Pipeline register: flush empties it, capture (re)loads it, a plain handshake drains it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid   <= 1'b0;
         out_type    <= '0;
         out_rd      <= '0;
         out_rs      <= '0;
         out_imm     <= '0;
         out_illegal <= 1'b0;
         op_q        <= '0;
      end else if (flush) begin
         out_valid   <= 1'b0;
      end else if (capture) begin
         out_valid   <= 1'b1;
         out_type    <= dec_type;
         out_rd      <= in_rd;
         out_rs      <= in_rs;
         out_imm     <= in_imm;
         out_illegal <= dec_illegal;
         op_q        <= in_op;
      end else if (retire) begin
         out_valid   <= 1'b0;
      end
   end

   // Retire counters: one per opcode, legal entries only, saturating at all-ones.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < NUM_OP; k++) begin
            cnt_q[k] <= '0;
         end
      end else if (retire && !out_illegal && (cnt_q[op_q] != {CNT_W{1'b1}})) begin
         cnt_q[op_q] <= cnt_q[op_q] + 1'b1;
      end
   end

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: default instance plus an instance with opcode 1 masked and 3-bit counters.
// Latency: expects 1-cycle capture-to-valid, counters visible the cycle after retire.
// Backpressure: stalls downstream and checks held outputs stay stable and in_ready drops.
module tb_decode_stage;
   import decode_stage_pkg::*;

   localparam logic [3:0] CFG_EN = 4'b1101;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [7:0]  in_inst;
   logic        flush;
   logic        out_ready;
   logic [1:0]  cnt_sel;

   logic        d_in_ready, d_out_valid, d_ill;
   logic [3:0]  d_type;
   logic [1:0]  d_rd, d_rs;
   logic [3:0]  d_imm;
   logic [15:0] d_cnt;

   logic        c_in_ready, c_out_valid, c_ill;
   logic [3:0]  c_type;
   logic [1:0]  c_rd, c_rs;
   logic [3:0]  c_imm;
   logic [2:0]  c_cnt;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [1:0] op;
      logic [1:0] rd;
      logic [1:0] rs;
      logic [3:0] imm;
   } exp_t;

   exp_t q[$];

   logic [7:0] stream [4] = '{8'h01, 8'h56, 8'hAB, 8'hFC};

   always #5 clk = ~clk;

   decode_stage u_def (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(d_in_ready),
      .in_inst(in_inst), .flush(flush), .out_valid(d_out_valid), .out_ready(out_ready),
      .out_type(d_type), .out_rd(d_rd), .out_rs(d_rs), .out_imm(d_imm),
      .out_illegal(d_ill), .cnt_sel(cnt_sel), .cnt_val(d_cnt)
   );

   decode_stage #(.OP_EN(CFG_EN), .CNT_W(3)) u_cfg (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(c_in_ready),
      .in_inst(in_inst), .flush(flush), .out_valid(c_out_valid), .out_ready(out_ready),
      .out_type(c_type), .out_rd(c_rd), .out_rs(c_rs), .out_imm(c_imm),
      .out_illegal(c_ill), .cnt_sel(cnt_sel), .cnt_val(c_cnt)
   );

   function automatic exp_t mk(input logic [7:0] i);
      exp_t e;
      e.op  = i[7:6];
      e.rd  = i[5:4];
      e.rs  = i[3:2];
      e.imm = i[3:0];
      return e;
   endfunction

   function automatic logic [3:0] onehot(input logic [1:0] op);
      logic [3:0] r;
      r = 4'b0000;
      r[op] = 1'b1;
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // One stimulus cycle; records the expected entry when the DUT accepts it.
   task automatic step(input logic v, input logic [7:0] inst, input logic ordy,
                       input logic fl, input logic rst);
      in_valid  = v;
      in_inst   = inst;
      out_ready = ordy;
      flush     = fl;
      rst_n     = rst;
      @(negedge clk);
      if (!rst || fl) q.delete();
      else if (v && d_in_ready) q.push_back(mk(inst));
      @(posedge clk);
      #1;
   endtask

   task automatic chk_cnt(input logic [1:0] sel, input int e_def, input int e_cfg);
      in_valid = 1'b0;
      flush    = 1'b0;
      cnt_sel  = sel;
      @(negedge clk);
      check($sformatf("cnt_def[%0d]", sel), 32'(d_cnt), e_def);
      check($sformatf("cnt_cfg[%0d]", sel), 32'(c_cnt), e_cfg);
      @(posedge clk);
      #1;
   endtask

   // Monitor: pops the scoreboard on every output handshake and checks stall stability.
   logic        stall_prev = 1'b0;
   logic [17:0] snap;

   always @(negedge clk) begin
      exp_t e;
      if (rst_n && !flush) begin
         if (stall_prev) begin
            check("hold_valid", 32'(d_out_valid), 1);
            check("hold_stable", 32'({d_type, d_rd, d_rs, d_imm, d_ill, c_type, c_ill}), 32'(snap));
         end
         if (d_out_valid && out_ready) begin
            if (q.size() == 0) begin
               check("unexpected_output", 32'(d_out_valid), 0);
            end else begin
               e = q.pop_front();
               check("cfg_valid", 32'(c_out_valid), 1);
               check("rd", 32'(d_rd), 32'(e.rd));
               check("rs", 32'(d_rs), 32'(e.rs));
               check("imm", 32'(d_imm), 32'(e.imm));
               check("type_def", 32'(d_type), 32'(onehot(e.op)));
               check("ill_def", 32'(d_ill), 0);
               check("type_cfg", 32'(c_type), CFG_EN[e.op] ? 32'(onehot(e.op)) : 0);
               check("ill_cfg", 32'(c_ill), CFG_EN[e.op] ? 0 : 1);
            end
         end
      end
      stall_prev = rst_n && !flush && d_out_valid && !out_ready;
      snap       = {d_type, d_rd, d_rs, d_imm, d_ill, c_type, c_ill};
   end

   // Time bound so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      int idx;
      in_valid = 0; in_inst = 0; flush = 0; out_ready = 1; cnt_sel = 0; rst_n = 0;

      // Reset state
      step(0, 8'h00, 1, 0, 0);
      step(0, 8'h00, 1, 0, 0);
      rst_n = 1;
      @(negedge clk);
      check("rst_out_valid", 32'(d_out_valid), 0);
      check("rst_out_type", 32'(d_type), 0);
      check("rst_fields", 32'({d_rd, d_rs, d_imm, d_ill}), 0);
      check("rst_in_ready", 32'(d_in_ready), 1);
      @(posedge clk); #1;
      for (int s = 0; s < 4; s++) chk_cnt(2'(s), 0, 0);

      // Single li instruction, 1-cycle latency
      step(1, 8'b10_01_1011, 1, 0, 1);
      in_valid = 0;
      @(negedge clk);
      check("li_latency_valid", 32'(d_out_valid), 1);
      check("li_type", 32'(d_type), 32'(4'b0100));
      check("li_rd", 32'(d_rd), 1);
      check("li_rs", 32'(d_rs), 2);
      check("li_imm", 32'(d_imm), 32'hB);
      @(posedge clk); #1;
      @(negedge clk);
      check("li_drained", 32'(d_out_valid), 0);
      @(posedge clk); #1;
      chk_cnt(2, 1, 1);

      // Back-to-back stream with a 3-cycle downstream stall after the first
      idx = 0;
      for (int c = 0; c < 12; c++) begin
         out_ready = !(c >= 1 && c <= 3);
         in_valid  = (idx < 4);
         in_inst   = stream[(idx < 4) ? idx : 0];
         flush     = 0;
         @(negedge clk);
         if (c >= 1 && c <= 3) check("stall_in_ready", 32'(d_in_ready), 0);
         if (in_valid && d_in_ready) begin
            q.push_back(mk(in_inst));
            idx++;
         end
         @(posedge clk); #1;
      end
      check("stream_all_accepted", idx, 4);
      check("stream_drained", q.size(), 0);
      chk_cnt(0, 1, 1);
      chk_cnt(1, 1, 0);
      chk_cnt(2, 2, 2);
      chk_cnt(3, 1, 1);

      // Flush a held entry while downstream is stalled
      step(1, 8'hC5, 0, 0, 1);
      step(0, 8'h00, 0, 0, 1);
      step(1, 8'h00, 0, 1, 1);
      in_valid = 0; out_ready = 1;
      @(negedge clk);
      check("flush_stall_clears", 32'(d_out_valid), 0);
      @(posedge clk); #1;

      // Flush a held entry while downstream is ready: no retire, no capture
      step(1, 8'hC5, 0, 0, 1);
      step(1, 8'h00, 1, 1, 1);
      in_valid = 0;
      @(negedge clk);
      check("flush_ready_clears", 32'(d_out_valid), 0);
      @(posedge clk); #1;
      @(negedge clk);
      check("flush_no_capture", 32'(d_out_valid), 0);
      @(posedge clk); #1;
      chk_cnt(3, 1, 1);
      chk_cnt(0, 1, 1);

      // Nine adds: 16-bit counter reaches 10, 3-bit counter saturates at 7
      for (int k = 0; k < 9; k++) step(1, {2'b00, 6'(k)}, 1, 0, 1);
      step(0, 8'h00, 1, 0, 1);
      chk_cnt(0, 10, 7);

      // Reset while an entry is held and counters are non-zero
      step(1, 8'h80, 0, 0, 1);
      step(1, 8'h40, 1, 0, 0);
      rst_n = 1; in_valid = 0;
      @(negedge clk);
      check("rst2_out_valid", 32'(d_out_valid), 0);
      check("rst2_in_ready", 32'(d_in_ready), 1);
      @(posedge clk); #1;
      for (int s = 0; s < 4; s++) chk_cnt(2'(s), 0, 0);

      check("scoreboard_empty", q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
